// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared constants for the shift-add sequential multiplier.
// Holds the FSM state codes, the datapath register select codes, the default
// operand width and the iteration-counter width derivation.
package seq_mul_pkg;

  // Default operand width in bits.
  localparam int DEFAULT_WIDTH = 8;

  // FSM state codes; 2'd3 is illegal and recovers to IDLE.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Select codes shared by the acc/mcand/mplr/cnt register slices.
  localparam logic [1:0] SEL_HOLD = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_STEP = 2'd2;

  // Product register source select.
  localparam logic PSEL_NEXT = 1'b0;  // acc after this cycle's partial product
  localparam logic PSEL_ACC  = 1'b1;  // acc as it stands (no iteration)

  // Iteration counter width: enough to count 0..WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/seq_mul_dp.sv
// seq_mul_dp: datapath of the sequential multiplier.
// Owns acc, mcand, mplr, cnt and the held product register. The FSM steers
// every slice with a load/step/hold select plus an enable; the product
// register has its own enable and source select.
// Optional macro SEQ_MUL_EARLY_TERM_EN exposes the mplr==0 status flag.
module seq_mul_dp
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         op_sel,
  input  logic               op_en,
  input  logic               prod_en,
  input  logic               prod_sel,
  output logic               last_iter,
`ifdef SEQ_MUL_EARLY_TERM_EN
  output logic               mplr_zero,
`endif
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplr_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH-1:0] product_r;

  logic [2*WIDTH-1:0] acc_next_s;
  logic [2*WIDTH-1:0] acc_d_s;
  logic [2*WIDTH-1:0] mcand_d_s;
  logic [WIDTH-1:0]   mplr_d_s;
  logic [CNT_W-1:0]   cnt_d_s;

  // Partial-product add; wraps mod 2^(2*WIDTH) but cannot overflow for unsigned operands.
  always_comb begin
    acc_next_s = acc_r + (mplr_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
  end

  // Next-value mux for each slice: load operands, take one shift-add step, or hold.
  always_comb begin
    acc_d_s   = acc_r;
    mcand_d_s = mcand_r;
    mplr_d_s  = mplr_r;
    cnt_d_s   = cnt_r;
    case (op_sel)
      SEL_LOAD: begin
        acc_d_s   = {(2*WIDTH){1'b0}};
        mcand_d_s = {{WIDTH{1'b0}}, a};
        mplr_d_s  = b;
        cnt_d_s   = {CNT_W{1'b0}};
      end
      SEL_STEP: begin
        acc_d_s   = acc_next_s;
        mcand_d_s = mcand_r << 1;
        mplr_d_s  = mplr_r >> 1;
        cnt_d_s   = cnt_r + CNT_ONE;
      end
      default: begin
        acc_d_s   = acc_r;
        mcand_d_s = mcand_r;
        mplr_d_s  = mplr_r;
        cnt_d_s   = cnt_r;
      end
    endcase
  end

  // Working registers: cleared by reset, updated only when the FSM enables them.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r   <= {(2*WIDTH){1'b0}};
      mcand_r <= {(2*WIDTH){1'b0}};
      mplr_r  <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else if (op_en) begin
      acc_r   <= acc_d_s;
      mcand_r <= mcand_d_s;
      mplr_r  <= mplr_d_s;
      cnt_r   <= cnt_d_s;
    end
  end

  // Held product register: written only on DONE entry, otherwise keeps its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      product_r <= {(2*WIDTH){1'b0}};
    end else if (prod_en) begin
      product_r <= (prod_sel == PSEL_ACC) ? acc_r : acc_next_s;
    end
  end

  assign last_iter = (cnt_r == LAST_CNT);
`ifdef SEQ_MUL_EARLY_TERM_EN
  assign mplr_zero = (mplr_r == {WIDTH{1'b0}});
`endif
  assign product   = product_r;

endmodule

// File: rtl/seq_mul_unit.sv
// seq_mul_unit: shift-add sequential multiplier with start/busy/done handshake.
// The top holds only the IDLE/RUN/DONE controller and the busy/done decode;
// all arithmetic state lives in seq_mul_dp.
// Optional macro SEQ_MUL_EARLY_TERM_EN: finish as soon as the remaining
// multiplier bits are all zero.
module seq_mul_unit
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic [1:0] state_r;
  logic [1:0] next_state_s;
  logic       busy_r;
  logic       done_r;

  logic [1:0] op_sel_s;
  logic       op_en_s;
  logic       prod_en_s;
  logic       prod_sel_s;
  logic       last_iter_s;
  logic       early_s;
`ifdef SEQ_MUL_EARLY_TERM_EN
  logic       mplr_zero_s;
`endif

  // Early-termination condition: mplr already exhausted at the start of a RUN cycle.
  always_comb begin
`ifdef SEQ_MUL_EARLY_TERM_EN
    early_s = mplr_zero_s;
`else
    early_s = 1'b0;
`endif
  end

  // Controller: next state plus datapath select/enable for the current cycle.
  always_comb begin
    next_state_s = state_r;
    op_sel_s     = SEL_HOLD;
    op_en_s      = 1'b0;
    prod_en_s    = 1'b0;
    prod_sel_s   = PSEL_NEXT;
    case (state_r)
      IDLE: begin
        if (start) begin
          op_sel_s     = SEL_LOAD;
          op_en_s      = 1'b1;
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (early_s) begin
          prod_en_s    = 1'b1;
          prod_sel_s   = PSEL_ACC;
          next_state_s = DONE;
        end else begin
          op_sel_s = SEL_STEP;
          op_en_s  = 1'b1;
          if (last_iter_s) begin
            prod_en_s    = 1'b1;
            prod_sel_s   = PSEL_NEXT;
            next_state_s = DONE;
          end else begin
            next_state_s = RUN;
          end
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        // Illegal code: back to IDLE with no register update.
        next_state_s = IDLE;
      end
    endcase
  end

  // State register with registered busy/done decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == RUN) || (next_state_s == DONE);
      done_r  <= (next_state_s == DONE);
    end
  end

  seq_mul_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .op_sel    (op_sel_s),
    .op_en     (op_en_s),
    .prod_en   (prod_en_s),
    .prod_sel  (prod_sel_s),
    .last_iter (last_iter_s),
`ifdef SEQ_MUL_EARLY_TERM_EN
    .mplr_zero (mplr_zero_s),
`endif
    .product   (product)
  );

  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_seq_mul_unit.sv
// tb_seq_mul_unit: self-checking bench for seq_mul_unit (WIDTH=8).
// A behavioural model (remaining-cycle count plus a*b) predicts busy, done
// and product every cycle; directed operations pin the model with literals.
module tb_seq_mul_unit;

  localparam int W = 8;
`ifdef SEQ_MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy;
  logic          done;
  logic [2*W-1:0] product;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  // behavioural model state
  bit            m_busy = 1'b0;
  bit            m_done = 1'b0;
  logic [2*W-1:0] m_prod = '0;
  logic [2*W-1:0] m_pend = '0;
  int            m_rem  = 0;

  seq_mul_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Number of RUN cycles an operation with multiplier bv occupies.
  function automatic int run_len(input logic [W-1:0] bv);
    int k;
    k = 0;
    for (int i = 0; i < W; i++) if (bv[i]) k = i + 1;
    if (!EARLY) return W;
    if (k == W) return W;
    return k + 1;
  endfunction

  // Model advance at a clock edge given the inputs sampled at that edge.
  task automatic model_step(input logic r, input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb);
    if (r) begin
      m_busy = 1'b0; m_done = 1'b0; m_prod = '0; m_rem = 0;
    end else if (m_done) begin
      m_done = 1'b0; m_busy = 1'b0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_done = 1'b1;
        m_prod = m_pend;
      end
    end else if (s) begin
      m_busy = 1'b1;
      m_rem  = run_len(bb);
      m_pend = (2*W)'(aa) * (2*W)'(bb);
    end
  endtask

  // One cycle: drive inputs, clock edge, update model, return at the falling edge.
  task automatic tick(input logic r, input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb);
    rst = r; start = s; a = aa; b = bb;
    @(posedge clk);
    model_step(r, s, aa, bb);
    @(negedge clk);
  endtask

  // Per-cycle compare of the DUT against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("product", {16'd0, product}, {16'd0, m_prod});
    end
  end

  // Directed op: start in cycle 0, start pulses from noise mask, literal checks at DONE.
  task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input int exp_prod,
                        input int exp_cyc, input int exp_prev, input logic [63:0] noise);
    int cyc;
    bit seen;
    tick(1'b0, 1'b1, aa, bb);
    cyc = 1;
    chk("prev_held", {16'd0, product}, exp_prev);
    seen = done;
    while (!seen && cyc < 40) begin
      tick(1'b0, noise[cyc], W'($urandom), W'($urandom));
      cyc++;
      seen = done;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("done_cycle", cyc, exp_cyc);
    chk("product_lit", {16'd0, product}, exp_prod);
    chk("model_pin", {16'd0, m_prod}, exp_prod);
    tick(1'b0, noise[cyc], W'($urandom), W'($urandom));
    chk("back_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [63:0] mask;
    logic [W-1:0] ra, rb;
    int cyc, nd, op_idx;
    int done_cyc [3];
    int done_val [3];
    logic [W-1:0] opa [3];
    logic [W-1:0] opb [3];
    bit s;

    // reset
    tick(1'b1, 1'b0, 8'd0, 8'd0);
    tick(1'b1, 1'b1, 8'd9, 8'd9);
    check_en = 1'b1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_product", {16'd0, product}, 32'd0);

    // basic ops
    run_op(8'd13, 8'd11, 143, EARLY ? 6 : 9, 0, 64'd0);
    run_op(8'd255, 8'd255, 65025, 9, 143, 64'd0);

    // ignored starts in RUN and DONE
    mask = 64'd0;
    mask[3] = 1'b1;
    mask[EARLY ? 5 : 9] = 1'b1;
    run_op(8'd5, 8'd6, 30, EARLY ? 5 : 9, 65025, mask);
    chk("no_queued_start", {31'd0, busy}, 32'd0);
    run_op(8'd7, 8'd7, 49, EARLY ? 5 : 9, 30, 64'd0);

    // reset mid-operation
    tick(1'b0, 1'b1, 8'd200, 8'd100);
    for (int i = 1; i < 4; i++) tick(1'b0, 1'b0, W'($urandom), W'($urandom));
    tick(1'b1, 1'b0, 8'd0, 8'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_product", {16'd0, product}, 32'd0);
    run_op(8'd3, 8'd4, 12, EARLY ? 5 : 9, 0, 64'd0);

    // multiplier patterns that exercise early termination
    run_op(8'd77, 8'd0, 0, EARLY ? 2 : 9, 12, 64'd0);
    run_op(8'd77, 8'd1, 77, EARLY ? 3 : 9, 0, 64'd0);
    run_op(8'd77, 8'd128, 9856, 9, 77, 64'd0);

    // start held high: back-to-back operations
    opa[0] = 8'd2; opb[0] = 8'd3;
    opa[1] = 8'd4; opb[1] = 8'd5;
    opa[2] = 8'd6; opb[2] = 8'd7;
    nd = 0; op_idx = 0; cyc = 0;
    while (nd < 3 && cyc < 60) begin
      s = (op_idx < 3);
      if (!m_busy && op_idx < 3) begin
        ra = opa[op_idx]; rb = opb[op_idx];
        op_idx++;
      end else begin
        ra = W'($urandom); rb = W'($urandom);
      end
      tick(1'b0, s, ra, rb);
      cyc++;
      if (done) begin
        done_cyc[nd] = cyc;
        done_val[nd] = int'(product);
        nd++;
      end
    end
    chk("b2b_count", nd, 3);
    if (nd == 3) begin
      chk("b2b_cyc0", done_cyc[0], EARLY ? 4 : 9);
      chk("b2b_val0", done_val[0], 6);
      chk("b2b_cyc1", done_cyc[1], EARLY ? 10 : 19);
      chk("b2b_val1", done_val[1], 20);
      chk("b2b_cyc2", done_cyc[2], EARLY ? 16 : 29);
      chk("b2b_val2", done_val[2], 42);
    end
    tick(1'b0, 1'b0, 8'd0, 8'd0);

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 4))
        0: rb = 8'd0;
        1: rb = 8'd1;
        2: rb = 8'hFF;
        3: rb = W'(1) << $urandom_range(0, W-1);
        default: rb = W'($urandom);
      endcase
      ra = ($urandom_range(0, 3) == 0) ? 8'hFF : W'($urandom);
      tick(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0), ra, rb);
    end
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, W'($urandom), W'($urandom));
    chk("final_idle", {31'd0, busy}, 32'd0);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
